// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
// The nibble width is fixed at 4 bits, matching the single lookahead slice.
package cla_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, ADD, DONE} cla_seq_state_t;

  typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/cla_nibble_slice.sv
// 4-bit carry-lookahead adder slice. Every internal carry is a flat P/G
// expression of ci; c3 (carry into bit 3) is exposed for signed-overflow detection.
module cla_nibble_slice
  import cla_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    ci,
  output nibble_t s,
  output logic    co,
  output logic    c3
);
  nibble_t p;
  nibble_t g;
  logic c1;
  logic c2;

  assign p = a ^ b;
  assign g = a & b;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/cla_seq_adder.sv
// Signed WIDTH-bit adder that processes one nibble per cycle through a shared
// lookahead slice, with valid/ready handshakes on both sides.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);
  localparam int NNIB  = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  cla_seq_state_t   state_reg;
  cla_seq_state_t   state_next;
  logic             alive_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH:0]   sum_reg;
  logic             ovf_reg;

  nibble_t a_nib [NNIB];
  nibble_t b_nib [NNIB];
  nibble_t slice_s;
  logic    slice_co;
  logic    slice_c3;
  logic    last_nib;
  logic    accept;

  for (genvar gi = 0; gi < NNIB; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
    assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
  end

  cla_nibble_slice u_slice (
    .a  (a_nib[idx_reg]),
    .b  (b_nib[idx_reg]),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  assign last_nib  = (idx_reg == IDX_W'(NNIB - 1));
  assign accept    = in_valid & in_ready;
  assign sum       = sum_reg;
  assign ovf       = ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      alive_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      alive_reg <= 1'b1;
    end
  end

  // alive_reg keeps in_ready low until the first edge after reset release.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = alive_reg;
        if (in_valid && alive_reg) state_next = ADD;
      end
      ADD: begin
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? ADD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
      idx_reg   <= '0;
    end else if (state_reg == ADD) begin
      for (int i = 0; i < NNIB; i++) begin
        if (idx_reg == IDX_W'(i)) sum_reg[i*NIBBLE_W +: NIBBLE_W] <= slice_s;
      end
      carry_reg <= slice_co;
      if (last_nib) begin
        idx_reg        <= '0;
        sum_reg[WIDTH] <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_co;
        ovf_reg        <= slice_c3 ^ slice_co;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=8): signed sums, overflow, backpressure,
// same-edge consume/accept and reset during an add.
module tb_cla_seq_adder;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  cla_seq_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands (optionally consuming a pending result on the same edge),
  // then wait for out_valid and check the latency.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                      input logic consume, input string tag);
    int lat;
    a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = consume;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    a = 8'hA5; b = 8'h5A; cin = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 10);
    check({tag, "_latency"}, 32'(lat), 32'd2);
  endtask

  task automatic take(input logic [8:0] es, input logic eo, input string tag);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [8:0] es;
    logic       eo;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 9'h010, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1};
    vecs[3] = '{8'hFF, 8'h01, 1'b1, 9'h001, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 9'h046, 1'b0};
    vecs[5] = '{8'h9C, 8'h9C, 1'b0, 9'h138, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b0, $sformatf("vec%0d", i));
      take(vecs[i].es, vecs[i].eo, $sformatf("vec%0d", i));
    end

    // Held result under backpressure while new operands wave around.
    send(8'h0F, 8'h01, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'(i * 8'h11); b = 8'h22;
      tick();
      check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_sum", i), 32'(sum), 32'h010);
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // Consume 0x010 and accept 05+03 on the same edge.
    send(8'h05, 8'h03, 1'b0, 1'b1, "chain");
    take(9'h008, 1'b0, "chain");

    // Reset during the first ADD cycle discards 10+10.
    a = 8'h10; b = 8'h10; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("midrst%0d_out_valid", i), 32'(out_valid), 32'd0);
    end
    check("midrst_in_ready_back", 32'(in_ready), 32'd1);
    send(8'h01, 8'h01, 1'b0, 1'b0, "after_rst");
    take(9'h002, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
